ddr_data_port: RTL and testbench

Memory-side responder for the data cache's DDR request interface. Serves burst data loads (DATA_read_req), single-word jump-address loads (JMP_ADDR_read_req) and burst data stores (DATA_store_req) against a word-addressed on-chip memory port with 1-cycle read latency. It produces the beat counter, valid and write-request strobes and the interface state code that the cache consumes. It sits between the data cache and the backing memory model/controller.

---
 rtl/ddr_data_port.sv | 201 ++++++++++++++++++++
 tb/tb_ddr_data_port.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_data_port.sv
// ddr_data_port: memory-side responder for the data cache's DDR request port.
// Serves burst reads, single-word jump-address reads and burst stores against
// a word-addressed memory with 1-cycle read latency.
//
// Handshake: a request is accepted only in IDLE, and it is a level signal.
// The responder stays in DONE until the serviced request drops.
// A store word moves on every cycle in which wr_burst_data_req and
// data_to_ddr_rdy are both high; if either is low, nothing moves.
module ddr_data_port #(
  parameter int DATA_CACHE_DEPTH = 16,
  parameter int DATA_WIDTH       = 16,
  parameter int DDR_ADDR_WIDTH   = 28,
  parameter int MEM_ADDR_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DATA_read_req,
  input  logic                      JMP_ADDR_read_req,
  input  logic                      DATA_store_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
  input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
  input  logic                      data_to_ddr_rdy,
  output logic [DATA_WIDTH-1:0]     DATA_to_cache,
  output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
  output logic [9:0]                rd_cnt_data,
  output logic                      rd_burst_data_valid,
  output logic                      wr_burst_data_req,
  output logic [3:0]                state_interface_module,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_rd_en,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic                      mem_wr_en,
  output logic [DATA_WIDTH-1:0]     mem_wr_data
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_READ_DATA = 4'd1,
    S_READ_JMP  = 4'd2,
    S_STORE     = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    K_NONE  = 2'd0,
    K_STORE = 2'd1,
    K_READ  = 2'd2,
    K_JMP   = 2'd3
  } kind_t;

  localparam logic [9:0] DEPTH = 10'(DATA_CACHE_DEPTH);
  localparam int         ZW    = DDR_ADDR_WIDTH - DATA_WIDTH;

  state_t                    state_q, state_d;
  kind_t                     kind_q, kind_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [9:0]                idx_q, idx_d;       // reads issued / store words accepted
  logic [9:0]                rd_cnt_q, rd_cnt_d;
  logic                      valid_q, valid_d;
  logic [DDR_ADDR_WIDTH-1:0] jmp_q, jmp_d;

  logic                      rd_en_c, wr_en_c, wr_req_c, req_held_c;
  logic [9:0]                word_c;
  logic [DDR_ADDR_WIDTH-1:0] rd_data_ext;
  logic                      unused_addr_bits;

  assign rd_data_ext = {{ZW{1'b0}}, mem_rd_data};
  // Only the word-address bits of the request addresses are used.
  assign unused_addr_bits = ^{DATA_read_addr, DATA_write_addr};

  // State register and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NONE;
      base_q   <= '0;
      idx_q    <= '0;
      rd_cnt_q <= '0;
      valid_q  <= 1'b0;
      jmp_q    <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      rd_cnt_q <= rd_cnt_d;
      valid_q  <= valid_d;
      jmp_q    <= jmp_d;
    end
  end

  // Next-state logic and memory strobes.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    base_d     = base_q;
    idx_d      = idx_q;
    rd_cnt_d   = rd_cnt_q;
    valid_d    = valid_q;
    jmp_d      = jmp_q;
    rd_en_c    = 1'b0;
    wr_en_c    = 1'b0;
    wr_req_c   = 1'b0;
    word_c     = '0;
    req_held_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (DATA_store_req) begin
          state_d = S_STORE;
          kind_d  = K_STORE;
          base_d  = DATA_write_addr[MEM_ADDR_WIDTH+2:3];
        end else if (DATA_read_req) begin
          state_d = S_READ_DATA;
          kind_d  = K_READ;
          base_d  = DATA_read_addr[MEM_ADDR_WIDTH+2:3];
        end else if (JMP_ADDR_read_req) begin
          state_d = S_READ_JMP;
          kind_d  = K_JMP;
          base_d  = DATA_read_addr[MEM_ADDR_WIDTH+2:3];
        end
      end

      // Word 0 is read twice so beat c lines up with word c-2 from beat 2 on.
      S_READ_DATA: begin
        if (idx_q <= DEPTH) begin
          rd_en_c  = 1'b1;
          word_c   = (idx_q == 10'd0) ? 10'd0 : idx_q - 10'd1;
          idx_d    = idx_q + 10'd1;
          rd_cnt_d = idx_q + 10'd1;
          valid_d  = 1'b1;
        end else begin
          valid_d = 1'b0;
          state_d = S_DONE;
        end
      end

      // First cycle issues the read, second cycle presents the beat and
      // latches the jump address for the cache to keep.
      S_READ_JMP: begin
        if (idx_q == 10'd0) begin
          rd_en_c  = 1'b1;
          idx_d    = 10'd1;
          rd_cnt_d = 10'd1;
          valid_d  = 1'b1;
        end else begin
          valid_d = 1'b0;
          jmp_d   = rd_data_ext;
          state_d = S_DONE;
        end
      end

      S_STORE: begin
        wr_req_c = 1'b1;
        word_c   = idx_q;
        if (data_to_ddr_rdy) begin
          wr_en_c = 1'b1;
          idx_d   = idx_q + 10'd1;
          if (idx_q == DEPTH - 10'd1) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        case (kind_q)
          K_STORE: req_held_c = DATA_store_req;
          K_READ:  req_held_c = DATA_read_req;
          K_JMP:   req_held_c = JMP_ADDR_read_req;
          default: req_held_c = 1'b0;
        endcase
        if (!req_held_c) begin
          rd_cnt_d = '0;
          kind_d   = K_NONE;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are suppressed while rst is high so a reset mid-burst writes nothing.
  assign mem_rd_en   = rd_en_c & ~rst;
  assign mem_wr_en   = wr_en_c & ~rst;
  assign mem_addr    = (rd_en_c | wr_en_c) ? base_q + MEM_ADDR_WIDTH'(word_c) : '0;
  assign mem_wr_data = wr_en_c ? DATA_to_ddr : '0;

  // Beat data comes straight from the registered memory output, aligned with
  // the registered count and valid.
  assign DATA_to_cache     = valid_q ? mem_rd_data : '0;
  assign JMP_ADDR_to_cache = (state_q == S_READ_JMP && valid_q) ? rd_data_ext : jmp_q;

  assign rd_cnt_data            = rd_cnt_q;
  assign rd_burst_data_valid    = valid_q;
  assign wr_burst_data_req      = wr_req_c;
  assign state_interface_module = state_q;

endmodule

// File: tb/tb_ddr_data_port.sv
// tb_ddr_data_port: scoreboard bench for ddr_data_port with a behavioural
// 1-cycle-latency memory.
module tb_ddr_data_port;

  logic        clk;
  logic        rst;
  logic        DATA_read_req, JMP_ADDR_read_req, DATA_store_req;
  logic [27:0] DATA_read_addr, DATA_write_addr;
  logic [15:0] DATA_to_ddr;
  logic        data_to_ddr_rdy;
  logic [15:0] DATA_to_cache;
  logic [27:0] JMP_ADDR_to_cache;
  logic [9:0]  rd_cnt_data;
  logic        rd_burst_data_valid, wr_burst_data_req;
  logic [3:0]  state_interface_module;
  logic [15:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_rd_data, mem_wr_data;

  logic [15:0] mem [0:65535];
  logic [25:0] rd_exp_q[$];   // {rd_cnt_data, DATA_to_cache}
  logic [31:0] wr_exp_q[$];   // {mem_addr, mem_wr_data}
  int total;
  int bad;

  ddr_data_port dut (
    .clk(clk), .rst(rst),
    .DATA_read_req(DATA_read_req), .JMP_ADDR_read_req(JMP_ADDR_read_req),
    .DATA_store_req(DATA_store_req),
    .DATA_read_addr(DATA_read_addr), .DATA_write_addr(DATA_write_addr),
    .DATA_to_ddr(DATA_to_ddr), .data_to_ddr_rdy(data_to_ddr_rdy),
    .DATA_to_cache(DATA_to_cache), .JMP_ADDR_to_cache(JMP_ADDR_to_cache),
    .rd_cnt_data(rd_cnt_data), .rd_burst_data_valid(rd_burst_data_valid),
    .wr_burst_data_req(wr_burst_data_req),
    .state_interface_module(state_interface_module),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, write on the clock edge.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops expected beats and writes as the DUT produces them.
  always @(negedge clk) begin
    check("rd_wr_excl", 64'(mem_rd_en & mem_wr_en), 64'd0);
    if (rd_burst_data_valid) begin
      if (rd_exp_q.size() == 0) check("rd_beat_unexp", 64'(rd_exp_q.size()), 64'd1);
      else check("rd_beat", {38'd0, rd_cnt_data, DATA_to_cache}, 64'(rd_exp_q.pop_front()));
    end
    if (mem_wr_en) begin
      if (wr_exp_q.size() == 0) check("wr_unexp", 64'(wr_exp_q.size()), 64'd1);
      else check("wr_word", {32'd0, mem_addr, mem_wr_data}, 64'(wr_exp_q.pop_front()));
    end
  end

  task automatic push_read_exp(input logic [27:0] addr);
    logic [15:0] base;
    logic [15:0] w;
    base = addr[18:3];
    for (int c = 1; c <= 17; c++) begin
      w = (c == 1) ? base : base + 16'(c - 2);
      rd_exp_q.push_back({10'(c), mem[w]});
    end
  endtask

  task automatic do_read(input logic [27:0] addr);
    push_read_exp(addr);
    DATA_read_req  = 1'b1;
    DATA_read_addr = addr;
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_first_state", 64'(state_interface_module), 64'd1);
    check("rd_first_en", 64'(mem_rd_en), 64'd1);
    check("rd_first_addr", 64'(mem_addr), 64'(addr[18:3]));
    check("rd_first_novalid", 64'(rd_burst_data_valid), 64'd0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      check("rd_valid_run", 64'(rd_burst_data_valid), 64'd1);
    end
    @(negedge clk);
    check("rd_end_valid", 64'(rd_burst_data_valid), 64'd0);
    check("rd_end_cnt", 64'(rd_cnt_data), 64'd17);
    check("rd_end_state", 64'(state_interface_module), 64'd10);
    @(negedge clk);
    check("rd_hold_cnt", 64'(rd_cnt_data), 64'd17);
    check("rd_hold_state", 64'(state_interface_module), 64'd10);
    DATA_read_req = 1'b0;
    @(negedge clk);
    check("rd_clr_cnt", 64'(rd_cnt_data), 64'd0);
    check("rd_clr_state", 64'(state_interface_module), 64'd0);
  endtask

  task automatic do_store(input logic [27:0] addr, input bit stall);
    logic [15:0] base;
    logic [15:0] wd [16];
    int j;
    int cyc;
    bit tog;
    base = addr[18:3];
    for (int i = 0; i < 16; i++) begin
      wd[i] = 16'($urandom_range(0, 65535));
      wr_exp_q.push_back({base + 16'(i), wd[i]});
    end
    DATA_store_req  = 1'b1;
    DATA_write_addr = addr;
    data_to_ddr_rdy = 1'b0;
    @(posedge clk); #1;
    j = 0; cyc = 0; tog = 1'b1;
    while (j < 16 && cyc < 100) begin
      data_to_ddr_rdy = tog;
      DATA_to_ddr     = wd[j];
      @(negedge clk);
      check("st_state", 64'(state_interface_module), 64'd9);
      check("st_wreq", 64'(wr_burst_data_req), 64'd1);
      if (!tog) check("st_stall_nowr", 64'(mem_wr_en), 64'd0);
      @(posedge clk); #1;
      if (tog) j++;
      tog = stall ? !tog : 1'b1;
      cyc++;
    end
    data_to_ddr_rdy = 1'b0;
    check("st_cycles", 64'(cyc), stall ? 64'd31 : 64'd16);
    @(negedge clk);
    check("st_done_state", 64'(state_interface_module), 64'd10);
    check("st_done_wreq", 64'(wr_burst_data_req), 64'd0);
    DATA_store_req = 1'b0;
    @(negedge clk);
    check("st_idle", 64'(state_interface_module), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wd4 [5];
    total = 0;
    bad   = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7 + 3);
    for (int i = 0; i < 16; i++) mem[16'h0100 + 16'(i)] = 16'hA000 + 16'(i);
    mem[16'h0040] = 16'h1234;
    mem[16'h0604] = 16'hDEAD;

    rst = 1'b1;
    DATA_read_req = 1'b0; JMP_ADDR_read_req = 1'b0; DATA_store_req = 1'b0;
    DATA_read_addr = '0; DATA_write_addr = '0;
    DATA_to_ddr = '0; data_to_ddr_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(state_interface_module), 64'd0);
    check("rst_cnt", 64'(rd_cnt_data), 64'd0);
    check("rst_valid", 64'(rd_burst_data_valid), 64'd0);
    check("rst_wreq", 64'(wr_burst_data_req), 64'd0);
    check("rst_jmp", 64'(JMP_ADDR_to_cache), 64'd0);
    check("rst_data", 64'(DATA_to_cache), 64'd0);
    check("rst_strobes", 64'({mem_rd_en, mem_wr_en}), 64'd0);

    // Burst read of mem[0x100..0x10F].
    do_read(28'h0000800);

    // Jump-address read of mem[0x40].
    JMP_ADDR_read_req = 1'b1;
    DATA_read_addr    = 28'h0000200;
    rd_exp_q.push_back({10'd1, 16'h1234});
    @(posedge clk); #1;
    @(negedge clk);
    check("jmp_state", 64'(state_interface_module), 64'd2);
    check("jmp_rd_en", 64'(mem_rd_en), 64'd1);
    check("jmp_addr", 64'(mem_addr), 64'h40);
    @(negedge clk);
    check("jmp_valid", 64'(rd_burst_data_valid), 64'd1);
    check("jmp_out_beat", 64'(JMP_ADDR_to_cache), 64'h0001234);
    @(negedge clk);
    check("jmp_end_valid", 64'(rd_burst_data_valid), 64'd0);
    check("jmp_end_state", 64'(state_interface_module), 64'd10);
    check("jmp_end_cnt", 64'(rd_cnt_data), 64'd1);
    check("jmp_out_held", 64'(JMP_ADDR_to_cache), 64'h0001234);
    JMP_ADDR_read_req = 1'b0;
    @(negedge clk);
    check("jmp_clr_state", 64'(state_interface_module), 64'd0);
    check("jmp_clr_cnt", 64'(rd_cnt_data), 64'd0);
    check("jmp_out_kept", 64'(JMP_ADDR_to_cache), 64'h0001234);

    // Store with alternating data_to_ddr_rdy to mem[0x80..0x8F].
    do_store(28'h0000400, 1'b1);

    // Store and read requested together: store first, read afterwards.
    push_read_exp(28'h0001000);
    DATA_read_req  = 1'b1;
    DATA_read_addr = 28'h0001000;
    do_store(28'h0002000, 1'b0);
    @(negedge clk);
    check("pri_rd_state", 64'(state_interface_module), 64'd1);
    for (int i = 0; i < 40 && rd_exp_q.size() != 0; i++) @(negedge clk);
    check("pri_rd_drained", 64'(rd_exp_q.size()), 64'd0);
    @(negedge clk);
    check("pri_rd_done", 64'(state_interface_module), 64'd10);
    check("pri_rd_cnt", 64'(rd_cnt_data), 64'd17);
    DATA_read_req = 1'b0;
    @(negedge clk);
    check("pri_idle", 64'(state_interface_module), 64'd0);

    // Read whose word addresses wrap past 0xFFFF.
    for (int i = 0; i < 8; i++) begin
      mem[16'hFFF8 + 16'(i)] = 16'($urandom_range(0, 65535));
      mem[16'(i)]            = 16'($urandom_range(0, 65535));
    end
    do_read(28'h007FFC0);

    // Reset during the fifth word of a store: only four writes land.
    for (int i = 0; i < 5; i++) wd4[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 4; i++) wr_exp_q.push_back({16'h0600 + 16'(i), wd4[i]});
    DATA_store_req  = 1'b1;
    DATA_write_addr = 28'h0003000;
    data_to_ddr_rdy = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      data_to_ddr_rdy = 1'b1;
      DATA_to_ddr     = wd4[i];
      @(posedge clk); #1;
    end
    DATA_to_ddr = wd4[4];
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_nowr", 64'(mem_wr_en), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    DATA_store_req  = 1'b0;
    data_to_ddr_rdy = 1'b0;
    @(negedge clk);
    check("rst_mid_state", 64'(state_interface_module), 64'd0);
    check("rst_mid_wreq", 64'(wr_burst_data_req), 64'd0);
    check("rst_mid_strobes", 64'({mem_rd_en, mem_wr_en}), 64'd0);
    check("rst_mid_cnt", 64'(rd_cnt_data), 64'd0);
    check("rst_mid_jmp", 64'(JMP_ADDR_to_cache), 64'd0);
    check("rst_mid_data", 64'(DATA_to_cache), 64'd0);
    check("rst_mid_waddr", 64'(mem_addr), 64'd0);
    check("rst_mid_sentinel", 64'(mem[16'h0604]), 64'hDEAD);
    check("rst_mid_writes", 64'(wr_exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    check("final_rd_q", 64'(rd_exp_q.size()), 64'd0);
    check("final_wr_q", 64'(wr_exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
